// File: rtl/tff_seq_pkg.sv
// Shared types for the toggle-flop bank sequencer: command opcodes and FSM states.
package tff_seq_pkg;

  localparam int unsigned OP_W = 2;
  localparam int unsigned ST_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_LOAD  = 2'b00,
    OP_UP    = 2'b01,
    OP_DOWN  = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE  = 2'b00,
    ST_APPLY = 2'b01,
    ST_RUN   = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/tff_cell.sv
// Single toggle flip-flop; reset has priority over toggle.
module tff_cell (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else if (t) begin
      q <= ~q;
    end
  end

endmodule

// File: rtl/tff_bank_sequencer.sv
// Sequences a bank of toggle flip-flops as a loadable up/down counter.
// Optional abort port pair enabled by defining TFF_SEQ_ABORT_EN.
module tff_bank_sequencer
  import tff_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  input  logic             pause,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] t_vec,
  output logic             busy,
  output logic             done
`ifdef TFF_SEQ_ABORT_EN
  ,
  input  logic             abort,
  output logic             aborted
`endif
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] arg_q, arg_d;
  logic [WIDTH-1:0] up_mask, dn_mask;
  logic             abort_c;

`ifdef TFF_SEQ_ABORT_EN
  assign abort_c = abort;
`else
  assign abort_c = 1'b0;
`endif

  assign cmd_ready = (state_q == ST_IDLE) && !rst;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);

  // Ripple-carry / ripple-borrow toggle masks for a one-step count.
  always_comb begin
    logic acc_up;
    logic acc_dn;
    acc_up  = 1'b1;
    acc_dn  = 1'b1;
    up_mask = '0;
    dn_mask = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      up_mask[i] = acc_up;
      dn_mask[i] = acc_dn;
      acc_up     = acc_up & q[i];
      acc_dn     = acc_dn & ~q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_LOAD;
      arg_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      arg_q   <= arg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    arg_d   = arg_q;
    t_vec   = '0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_d  = op_e'(cmd_op);
          arg_d = (op_e'(cmd_op) == OP_CLEAR) ? '0 : cmd_arg;
          case (op_e'(cmd_op))
            OP_LOAD, OP_CLEAR: state_d = ST_APPLY;
            default:           state_d = ST_RUN;
          endcase
        end
      end
      ST_APPLY: begin
        if (!abort_c) begin
          t_vec = q ^ arg_q;
        end
        state_d = ST_DONE;
      end
      ST_RUN: begin
        if (abort_c || (q == arg_q)) begin
          state_d = ST_DONE;
        end else if (!pause) begin
          t_vec = (op_q == OP_DOWN) ? dn_mask : up_mask;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Each bit of the bank is its own T flop driven by the mask.
  for (genvar g = 0; g < WIDTH; g++) begin : g_bank
    tff_cell u_cell (
      .clk (clk),
      .rst (rst),
      .t   (t_vec[g]),
      .q   (q[g])
    );
  end

`ifdef TFF_SEQ_ABORT_EN
  // High exactly in the DONE cycle that follows an abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      aborted <= 1'b0;
    end else begin
      aborted <= abort && ((state_q == ST_APPLY) || (state_q == ST_RUN));
    end
  end
`endif

endmodule

// File: tb/tb_tff_bank_sequencer.sv
// Directed self-checking bench for tff_bank_sequencer (WIDTH=4).
module tb_tff_bank_sequencer;

  localparam int unsigned WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_arg;
  logic             pause;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] t_vec;
  logic             busy;
  logic             done;
`ifdef TFF_SEQ_ABORT_EN
  logic             abort;
  logic             aborted;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tff_bank_sequencer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_arg   (cmd_arg),
    .pause     (pause),
    .q         (q),
    .t_vec     (t_vec),
    .busy      (busy),
    .done      (done)
`ifdef TFF_SEQ_ABORT_EN
    ,
    .abort     (abort),
    .aborted   (aborted)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offers a command in the current cycle (accept cycle N); returns in cycle N+1.
  task automatic issue(input logic [1:0] op, input logic [WIDTH-1:0] arg);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Called in cycle N+1; checks that done first rises in cycle N+exp_lat.
  task automatic wait_done(input string tag, input int exp_lat);
    int lat;
    lat = 1;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    chk(tag, 16'(lat), 16'(exp_lat));
    tick();
  endtask

  logic [WIDTH-1:0] up_q [6] = '{4'b1110, 4'b1111, 4'b0000, 4'b0001, 4'b0010, 4'b0011};
  logic [WIDTH-1:0] up_t [6] = '{4'b0001, 4'b1111, 4'b0001, 4'b0011, 4'b0001, 4'b0000};

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_arg   = '0;
    pause     = 1'b0;
`ifdef TFF_SEQ_ABORT_EN
    abort     = 1'b0;
`endif
    tick();
    tick();
    chk("rst_q", 16'(q), 16'h0);
    chk("rst_ready", 16'(cmd_ready), 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_done", 16'(done), 16'h0);
    chk("rst_tvec", 16'(t_vec), 16'h0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 16'(cmd_ready), 16'h1);

    // LOAD 1010 from 0000
    issue(2'b00, 4'b1010);
    chk("load_n1_tvec", 16'(t_vec), 16'hA);
    chk("load_n1_q", 16'(q), 16'h0);
    chk("load_n1_done", 16'(done), 16'h0);
    chk("load_n1_ready", 16'(cmd_ready), 16'h0);
    chk("load_n1_busy", 16'(busy), 16'h1);
    tick();
    chk("load_n2_q", 16'(q), 16'hA);
    chk("load_n2_done", 16'(done), 16'h1);
    chk("load_n2_tvec", 16'(t_vec), 16'h0);
    tick();
    chk("load_n3_done", 16'(done), 16'h0);
    chk("load_n3_ready", 16'(cmd_ready), 16'h1);
    chk("load_n3_busy", 16'(busy), 16'h0);

    // UP 1110 -> 0011 with wrap
    issue(2'b00, 4'b1110);
    wait_done("load_1110_lat", 2);
    chk("load_1110_q", 16'(q), 16'hE);
    issue(2'b01, 4'b0011);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("up_q%0d", i), 16'(q), 16'(up_q[i]));
      chk($sformatf("up_t%0d", i), 16'(t_vec), 16'(up_t[i]));
      chk($sformatf("up_done%0d", i), 16'(done), 16'h0);
      tick();
    end
    chk("up_done_n7", 16'(done), 16'h1);
    chk("up_final_q", 16'(q), 16'h3);
    tick();

    // DOWN 0011 -> 0000 with two pause cycles
    issue(2'b10, 4'b0000);
    chk("dn_n1_q", 16'(q), 16'h3);
    chk("dn_n1_t", 16'(t_vec), 16'h1);
    tick();
    pause = 1'b1;
    #1;
    chk("dn_p1_q", 16'(q), 16'h2);
    chk("dn_p1_t", 16'(t_vec), 16'h0);
    tick();
    chk("dn_p2_q", 16'(q), 16'h2);
    chk("dn_p2_t", 16'(t_vec), 16'h0);
    tick();
    pause = 1'b0;
    #1;
    chk("dn_n4_q", 16'(q), 16'h2);
    chk("dn_n4_t", 16'(t_vec), 16'h3);
    tick();
    chk("dn_n5_q", 16'(q), 16'h1);
    tick();
    chk("dn_n6_q", 16'(q), 16'h0);
    chk("dn_n6_t", 16'(t_vec), 16'h0);
    chk("dn_n6_done", 16'(done), 16'h0);
    tick();
    chk("dn_n7_done", 16'(done), 16'h1);
    tick();

    // Held cmd_valid, UP with target already equal to q
    issue(2'b00, 4'b0101);
    wait_done("load_0101_lat", 2);
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_arg   = 4'b0101;
    tick();
    chk("hold_n1_ready", 16'(cmd_ready), 16'h0);
    chk("hold_n1_t", 16'(t_vec), 16'h0);
    chk("hold_n1_done", 16'(done), 16'h0);
    tick();
    chk("hold_n2_done", 16'(done), 16'h1);
    chk("hold_n2_ready", 16'(cmd_ready), 16'h0);
    chk("hold_n2_q", 16'(q), 16'h5);
    tick();
    chk("hold_n3_ready", 16'(cmd_ready), 16'h1);
    chk("hold_n3_busy", 16'(busy), 16'h0);
    tick();
    cmd_valid = 1'b0;
    chk("hold_n4_busy", 16'(busy), 16'h1);
    wait_done("hold_second_lat", 2);
    chk("hold_second_q", 16'(q), 16'h5);

    // CLEAR ignores arg, then reset in the middle of UP 0000 -> 1000
    issue(2'b11, 4'b1111);
    wait_done("clear_lat", 2);
    chk("clear_q", 16'(q), 16'h0);
    issue(2'b01, 4'b1000);
    for (int i = 0; i < 4; i++) tick();
    chk("rstrun_q", 16'(q), 16'h4);
    chk("rstrun_busy", 16'(busy), 16'h1);
    rst = 1'b1;
    tick();
    chk("rstrun_q_after", 16'(q), 16'h0);
    chk("rstrun_busy_after", 16'(busy), 16'h0);
    chk("rstrun_done_after", 16'(done), 16'h0);
    rst = 1'b0;
    tick();
    chk("rstrun_done_later", 16'(done), 16'h0);
    chk("rstrun_idle_ready", 16'(cmd_ready), 16'h1);
    chk("rstrun_q_later", 16'(q), 16'h0);

`ifdef TFF_SEQ_ABORT_EN
    issue(2'b01, 4'b1000);
    for (int i = 0; i < 4; i++) tick();
    chk("abort_q_pre", 16'(q), 16'h4);
    abort = 1'b1;
    #1;
    chk("abort_t", 16'(t_vec), 16'h0);
    tick();
    abort = 1'b0;
    chk("abort_done", 16'(done), 16'h1);
    chk("abort_aborted", 16'(aborted), 16'h1);
    chk("abort_q", 16'(q), 16'h4);
    tick();
    chk("abort_done_clr", 16'(done), 16'h0);
    chk("abort_aborted_clr", 16'(aborted), 16'h0);
    chk("abort_idle", 16'(busy), 16'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
